// File: rtl/queue_dispatcher_if.sv
// Downstream beat channel of the queue dispatcher: registered payload plus the
// index of the queue it was popped from, on a valid/ready handshake.
interface queue_dispatcher_if #(
    parameter int DATA_WIDTH   = 64,
    parameter int SOURCE_WIDTH = 2
);
    logic                    m_valid;
    logic                    m_ready;
    logic [DATA_WIDTH-1:0]   m_data;
    logic [SOURCE_WIDTH-1:0] m_source;

    modport master (output m_valid, m_data, m_source, input m_ready);
    modport slave  (input m_valid, m_data, m_source, output m_ready);
endinterface

// File: rtl/queue_dispatcher.sv
// Pops the scheduler-selected FWFT queue into a one-beat output register and
// keeps saturating per-queue service counters plus a sticky bad-selection flag.
module queue_dispatcher #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int DATA_WIDTH       = 64,
    parameter int COUNTER_WIDTH    = 16,
    localparam int SEL_W           = $clog2(NUMBER_OF_QUEUES)
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic                                              sched_valid,
    input  logic [SEL_W-1:0]                                  sched_selection,
    input  logic [NUMBER_OF_QUEUES-1:0]                       empty,
    input  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0]       queue_data,
    output logic [NUMBER_OF_QUEUES-1:0]                       pop,
    queue_dispatcher_if.master                                m,
    output logic [NUMBER_OF_QUEUES-1:0][COUNTER_WIDTH-1:0]    served_count,
    output logic                                              sel_error
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t                                             state_reg;
    logic                                               m_valid_reg;
    logic [DATA_WIDTH-1:0]                              m_data_reg;
    logic [SEL_W-1:0]                                   m_source_reg;
    logic                                               sel_error_reg;
    logic [NUMBER_OF_QUEUES-1:0][COUNTER_WIDTH-1:0]     count_reg;

    logic [NUMBER_OF_QUEUES-1:0]                        req_hit;
    logic                                               legal;
    logic                                               slot_free;
    logic [DATA_WIDTH-1:0]                              sel_data;

    // Per-queue match: an out-of-range selection hits nothing and so is illegal.
    generate
        for (genvar gi = 0; gi < NUMBER_OF_QUEUES; gi++) begin : g_queue
            assign req_hit[gi] = sched_valid && !empty[gi] &&
                                 (sched_selection == SEL_W'(gi));
            assign pop[gi]     = req_hit[gi] && slot_free && reset;
        end
    endgenerate

    assign legal     = |req_hit;
    assign slot_free = (state_reg == IDLE) || m.m_ready;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (req_hit[i]) sel_data = queue_data[i];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            m_valid_reg   <= 1'b0;
            m_data_reg    <= '0;
            m_source_reg  <= '0;
            sel_error_reg <= 1'b0;
        end else begin
            if (sched_valid && !legal) sel_error_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (legal) begin
                        m_data_reg   <= sel_data;
                        m_source_reg <= sched_selection;
                        m_valid_reg  <= 1'b1;
                        state_reg    <= HOLD;
                    end
                end
                HOLD: begin
                    // Reload on handshake keeps the stream bubble-free.
                    if (m.m_ready) begin
                        if (legal) begin
                            m_data_reg   <= sel_data;
                            m_source_reg <= sched_selection;
                        end else begin
                            m_valid_reg  <= 1'b0;
                            state_reg    <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
                if (pop[i] && (count_reg[i] != '1)) begin
                    count_reg[i] <= count_reg[i] + 1'b1;
                end
            end
        end
    end

    assign m.m_valid    = m_valid_reg;
    assign m.m_data     = m_data_reg;
    assign m.m_source   = m_source_reg;
    assign served_count = count_reg;
    assign sel_error    = sel_error_reg;
endmodule

// File: tb/tb_queue_dispatcher.sv
// Scoreboard bench: stimulus predicts pops/beats from a one-slot buffer model,
// a separate monitor checks every accepted beat against the expected queue.
module tb_queue_dispatcher;
    localparam int N  = 3;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int SW = $clog2(N);
    localparam int SAT = (1 << CW) - 1;

    logic                   clock;
    logic                   reset;
    logic                   sched_valid;
    logic [SW-1:0]          sched_selection;
    logic [N-1:0]           empty;
    logic [N-1:0][DW-1:0]   queue_data;
    logic [N-1:0]           pop;
    logic [N-1:0][CW-1:0]   served_count;
    logic                   sel_error;

    queue_dispatcher_if #(.DATA_WIDTH(DW), .SOURCE_WIDTH(SW)) m_if ();

    queue_dispatcher #(
        .NUMBER_OF_QUEUES(N),
        .DATA_WIDTH(DW),
        .COUNTER_WIDTH(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sched_valid(sched_valid),
        .sched_selection(sched_selection),
        .empty(empty),
        .queue_data(queue_data),
        .pop(pop),
        .m(m_if),
        .served_count(served_count),
        .sel_error(sel_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int              src;
        logic [DW-1:0]   data;
    } beat_t;

    beat_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    n_beats = 0;

    // Reference model: output slot occupancy, sticky error, service counts.
    bit    occ_m;
    bit    err_m;
    int    cnt_m[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic sv, input int sel, input logic [N-1:0] emp,
                         input logic rdy, input logic rst_v);
        bit           legal;
        bit           take;
        logic [N-1:0] exp_pop;
        @(negedge clock);
        reset           = rst_v;
        sched_valid     = sv;
        sched_selection = sel[SW-1:0];
        empty           = emp;
        m_if.m_ready    = rdy;
        for (int q = 0; q < N; q++) queue_data[q] = $urandom;
        #1;
        if (!rst_v) begin
            occ_m = 0;
            err_m = 0;
            for (int q = 0; q < N; q++) cnt_m[q] = 0;
            sb.delete();
        end
        legal   = rst_v && sv && (sel < N) && !emp[sel];
        take    = legal && (!occ_m || rdy);
        exp_pop = '0;
        if (take) exp_pop[sel] = 1'b1;
        chk("pop", 64'(pop), 64'(exp_pop));
        chk("m_valid", 64'(m_if.m_valid), 64'(occ_m));
        chk("sel_error", 64'(sel_error), 64'(err_m));
        for (int q = 0; q < N; q++) chk($sformatf("served_count[%0d]", q),
                                         64'(served_count[q]), 64'(cnt_m[q]));
        if (!rst_v) begin
            chk("m_data_rst", 64'(m_if.m_data), 64'd0);
            chk("m_source_rst", 64'(m_if.m_source), 64'd0);
        end else begin
            if (sv && !legal) err_m = 1;
            if (take) begin
                if (cnt_m[sel] < SAT) cnt_m[sel]++;
                sb.push_back('{sel, queue_data[sel]});
                occ_m = 1;
            end else if (occ_m && rdy) begin
                occ_m = 0;
            end
        end
    endtask

    // Monitor: every handshake must match the oldest predicted beat.
    initial begin
        beat_t b;
        forever begin
            @(negedge clock);
            #2;
            if (reset === 1'b1 && m_if.m_valid === 1'b1 && m_if.m_ready === 1'b1) begin
                n_beats++;
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'(m_if.m_source), 64'hFFFF_FFFF);
                end else begin
                    b = sb.pop_front();
                    $display("beat %0d: src=%0d data=%h", n_beats, m_if.m_source, m_if.m_data);
                    chk("m_source", 64'(m_if.m_source), 64'(b.src));
                    chk("m_data", 64'(m_if.m_data), 64'(b.data));
                end
            end
        end
    end

    initial begin
        reset           = 1'b1;
        sched_valid     = 1'b0;
        sched_selection = '0;
        empty           = '1;
        queue_data      = '0;
        m_if.m_ready    = 1'b1;

        // Reset held with a legal request pending.
        repeat (3) cycle(1, 2, '0, 1, 0);
        cycle(1, 2, '0, 1, 1);
        cycle(0, 0, '0, 1, 1);

        // Streaming back-to-back.
        for (int k = 0; k < 8; k++) cycle(1, k % N, '0, 1, 1);
        repeat (2) cycle(0, 0, '0, 1, 1);

        // Backpressure on a held beat from queue 1.
        cycle(1, 1, '0, 1, 1);
        repeat (5) cycle(1, 2, '0, 0, 1);
        cycle(1, 2, '0, 1, 1);
        repeat (2) cycle(0, 0, '0, 1, 1);

        // Illegal selections: out of range, then empty queue.
        cycle(1, 3, '0, 1, 1);
        cycle(1, 1, 3'b010, 1, 1);
        cycle(0, 0, '0, 1, 1);
        cycle(1, 0, '0, 1, 1);
        repeat (2) cycle(0, 0, '0, 1, 1);

        // Saturation of queue 0's counter.
        cycle(0, 0, '0, 1, 0);
        repeat (20) cycle(1, 0, '0, 1, 1);
        cycle(0, 0, '0, 1, 1);
        chk("sat_count0", 64'(served_count[0]), 64'(SAT));

        // Reset while a beat is held.
        cycle(1, 1, '0, 0, 1);
        cycle(0, 0, '0, 0, 1);
        cycle(0, 0, '0, 0, 0);

        // Randomized traffic with occasional reset.
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom_range(0, 9) != 0), $urandom_range(0, 3),
                  N'($urandom_range(0, 7) & $urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) != 0));
        end

        repeat (3) cycle(0, 0, '0, 1, 1);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
